// File: rtl/mpsoc_wb_arb_pkg.sv
// +------------------------------------------------------------------+
// | mpsoc_wb_arb_pkg : shared types/constants for the 3-master arb    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package mpsoc_wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  localparam logic [1:0] NO_OWNER    = 2'd3;
  localparam logic [1:0] M_OR1K_I    = 2'd0;
  localparam logic [1:0] M_OR1K_D    = 2'd1;
  localparam logic [1:0] M_DBG       = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mpsoc_wb_arb_rr.sv
// +------------------------------------------------------------------+
// | mpsoc_wb_arb_rr : 3-way round-robin picker, search from last+1   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mpsoc_wb_arb_rr (
  input  logic [2:0] i_req,
  input  logic [1:0] i_last,
  output logic [1:0] o_winner,
  output logic       o_valid
);
  import mpsoc_wb_arb_pkg::*;

  logic [1:0] w_ord [3];

  always_comb begin
    w_ord[0] = M_OR1K_I;
    w_ord[1] = M_OR1K_D;
    w_ord[2] = M_DBG;
    case (i_last)
      2'd0: begin
        w_ord[0] = M_OR1K_D;
        w_ord[1] = M_DBG;
        w_ord[2] = M_OR1K_I;
      end
      2'd1: begin
        w_ord[0] = M_DBG;
        w_ord[1] = M_OR1K_I;
        w_ord[2] = M_OR1K_D;
      end
      default: begin
        w_ord[0] = M_OR1K_I;
        w_ord[1] = M_OR1K_D;
        w_ord[2] = M_DBG;
      end
    endcase
  end

  always_comb begin
    o_valid  = |i_req;
    o_winner = NO_OWNER;
    if (i_req[w_ord[0]])      o_winner = w_ord[0];
    else if (i_req[w_ord[1]]) o_winner = w_ord[1];
    else if (i_req[w_ord[2]]) o_winner = w_ord[2];
  end

endmodule

`default_nettype wire

// File: rtl/mpsoc_wb_arb3.sv
// +------------------------------------------------------------------+
// | mpsoc_wb_arb3 : 3-master Wishbone arbiter with stall watchdog    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mpsoc_wb_arb3 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [3*AW-1:0]   m_adr_i,
  input  logic [3*DW-1:0]   m_dat_i,
  input  logic [3*DW/8-1:0] m_sel_i,
  input  logic [2:0]        m_we_i,
  input  logic [2:0]        m_cyc_i,
  input  logic [2:0]        m_stb_i,
  input  logic [8:0]        m_cti_i,
  input  logic [5:0]        m_bte_i,
  output logic [3*DW-1:0]   m_dat_o,
  output logic [2:0]        m_ack_o,
  output logic [2:0]        m_err_o,
  output logic [2:0]        m_rty_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  output logic [1:0]        grant_o
);
  import mpsoc_wb_arb_pkg::*;

  localparam int              SW    = DW / 8;
  localparam int              WDW   = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]  C_TMO = WDW'(TIMEOUT);

  // Entry 3 is the "no owner" slot: all zeros, so indexing by NO_OWNER idles the slave port.
  logic [AW-1:0] w_adr [4];
  logic [DW-1:0] w_dat [4];
  logic [SW-1:0] w_sel [4];
  logic [2:0]    w_cti [4];
  logic [1:0]    w_bte [4];
  logic          w_we  [4];
  logic          w_cyc [4];
  logic          w_stb [4];

  for (genvar k = 0; k < 3; k++) begin : g_unpack
    assign w_adr[k] = m_adr_i[k*AW +: AW];
    assign w_dat[k] = m_dat_i[k*DW +: DW];
    assign w_sel[k] = m_sel_i[k*SW +: SW];
    assign w_cti[k] = m_cti_i[k*3 +: 3];
    assign w_bte[k] = m_bte_i[k*2 +: 2];
    assign w_we[k]  = m_we_i[k];
    assign w_cyc[k] = m_cyc_i[k];
    assign w_stb[k] = m_stb_i[k];
  end

  assign w_adr[3] = '0;
  assign w_dat[3] = '0;
  assign w_sel[3] = '0;
  assign w_cti[3] = '0;
  assign w_bte[3] = '0;
  assign w_we[3]  = 1'b0;
  assign w_cyc[3] = 1'b0;
  assign w_stb[3] = 1'b0;

  arb_state_e     r_state;
  logic [1:0]     r_grant;
  logic [1:0]     r_last;
  logic [WDW-1:0] r_wdog;

  logic [1:0] w_win;
  logic       w_win_vld;
  logic       w_own_cyc;
  logic       w_own_stb;
  logic       w_hold;
  logic       w_resp;
  logic       w_timeout;

  mpsoc_wb_arb_rr u_rr (
    .i_req    (m_cyc_i),
    .i_last   (r_last),
    .o_winner (w_win),
    .o_valid  (w_win_vld)
  );

  assign w_own_cyc = w_cyc[r_grant];
  assign w_own_stb = w_stb[r_grant];
  assign w_hold    = (r_state == OWN) && w_own_cyc;
  assign w_resp    = s_ack_i | s_err_i | s_rty_i;
  // A real slave response in the expiry cycle takes precedence over the forced error.
  assign w_timeout = w_hold && w_own_stb && (r_wdog == C_TMO) && !w_resp;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
      r_grant <= NO_OWNER;
      r_last  <= M_DBG;
      r_wdog  <= '0;
    end else begin
      if (!w_hold) begin
        if (w_win_vld) begin
          r_state <= OWN;
          r_grant <= w_win;
          r_last  <= w_win;
        end else begin
          r_state <= IDLE;
          r_grant <= NO_OWNER;
        end
      end
      if (!w_hold || !w_own_stb || w_resp || w_timeout) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  assign s_adr_o = w_adr[r_grant];
  assign s_dat_o = w_dat[r_grant];
  assign s_sel_o = w_sel[r_grant];
  assign s_we_o  = w_we[r_grant];
  assign s_cti_o = w_cti[r_grant];
  assign s_bte_o = w_bte[r_grant];
  assign s_cyc_o = w_own_cyc;
  assign s_stb_o = w_own_stb && !w_timeout;
  assign grant_o = r_grant;

  for (genvar k = 0; k < 3; k++) begin : g_resp
    assign m_dat_o[k*DW +: DW] = s_dat_i;
    assign m_ack_o[k] = (r_grant == 2'(k)) && s_ack_i;
    assign m_err_o[k] = (r_grant == 2'(k)) && (s_err_i || w_timeout);
    assign m_rty_o[k] = (r_grant == 2'(k)) && s_rty_i;
  end

endmodule

`default_nettype wire

// File: tb/tb_mpsoc_wb_arb3.sv
// +------------------------------------------------------------------+
// | tb_mpsoc_wb_arb3 : scoreboard bench for the 3-master arbiter     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mpsoc_wb_arb3;
  import mpsoc_wb_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] K = 32'hA5A5_0000;

  typedef struct {
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [1:0]  grant;
    logic [31:0] dat;
    bit          chk_dat;
    bit          chk_stb0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [31:0] ma_adr [3];
  logic [3:0]  ma_sel [3];
  logic [2:0]  ma_cti [3];
  logic [1:0]  ma_bte [3];
  logic        ma_we  [3];
  logic        ma_cyc [3];
  logic        ma_stb [3];

  logic [3*AW-1:0] m_adr_i;
  logic [3*DW-1:0] m_dat_i;
  logic [11:0]     m_sel_i;
  logic [2:0]      m_we_i, m_cyc_i, m_stb_i;
  logic [8:0]      m_cti_i;
  logic [5:0]      m_bte_i;
  logic [3*DW-1:0] m_dat_o;
  logic [2:0]      m_ack_o, m_err_o, m_rty_o;
  logic [31:0]     s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]      s_sel_o;
  logic            s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic            s_ack_i;
  logic            s_err_i = 1'b0;
  logic            s_rty_i = 1'b0;
  logic [1:0]      grant_o;

  assign m_adr_i = {ma_adr[2], ma_adr[1], ma_adr[0]};
  assign m_dat_i = {32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
  assign m_sel_i = {ma_sel[2], ma_sel[1], ma_sel[0]};
  assign m_we_i  = {ma_we[2], ma_we[1], ma_we[0]};
  assign m_cyc_i = {ma_cyc[2], ma_cyc[1], ma_cyc[0]};
  assign m_stb_i = {ma_stb[2], ma_stb[1], ma_stb[0]};
  assign m_cti_i = {ma_cti[2], ma_cti[1], ma_cti[0]};
  assign m_bte_i = {ma_bte[2], ma_bte[1], ma_bte[0]};

  mpsoc_wb_arb3 #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int   chk_cnt = 0;
  int   err_cnt = 0;
  exp_t sb [$];
  exp_t e;
  int   slv_lat = 1;
  bit   slv_never = 1'b0;
  bit   abort = 1'b0;
  int   scnt;
  int   n0, n1, n2;
  bit   tr_en = 1'b0;
  logic [1:0] g_prev;
  logic [1:0] gtrace [$];
  logic [1:0] gexp [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [2:0] ack, input logic [2:0] err, input logic [1:0] g,
                          input logic [31:0] dat, input bit cd, input bit cs);
    exp_t x;
    x.ack = ack; x.err = err; x.grant = g; x.dat = dat; x.chk_dat = cd; x.chk_stb0 = cs;
    sb.push_back(x);
  endtask

  // Slave: acks slv_lat cycles after strobe seen, returns address ^ K
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack_i <= 1'b0;
      s_dat_i <= '0;
      scnt    <= 0;
    end else if (s_cyc_o && s_stb_o && !s_ack_i && !slv_never) begin
      if (scnt >= slv_lat - 1) begin
        s_ack_i <= 1'b1;
        s_dat_i <= s_adr_o ^ K;
        scnt    <= 0;
      end else begin
        scnt <= scnt + 1;
      end
    end else begin
      s_ack_i <= 1'b0;
      scnt    <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (|m_ack_o || |m_err_o || |m_rty_o)) begin
      if (sb.size() == 0) begin
        chk_cnt++;
        err_cnt++;
        $display("FAIL unexpected_resp: ack=%b err=%b rty=%b expected none", m_ack_o, m_err_o, m_rty_o);
      end else begin
        e = sb.pop_front();
        check("resp_ack", m_ack_o, e.ack);
        check("resp_err", m_err_o, e.err);
        check("resp_rty", m_rty_o, 3'b000);
        check("resp_grant", grant_o, e.grant);
        if (e.chk_dat)
          for (int k = 0; k < 3; k++) check("resp_dat", m_dat_o[k*32 +: 32], e.dat);
        if (e.chk_stb0) check("tmo_stb_low", s_stb_o, 1'b0);
      end
    end
    if (tr_en) begin
      if (grant_o != g_prev) gtrace.push_back(grant_o);
      g_prev = grant_o;
    end
  end

  task automatic do_access(input int k, input logic [31:0] adr, input int beats, output int n);
    n = 0;
    @(posedge clk); #1;
    ma_adr[k] = adr; ma_sel[k] = 4'hF; ma_we[k] = 1'b0; ma_bte[k] = BTE_LINEAR;
    ma_cti[k] = (beats > 1) ? CTI_INCR : CTI_CLASSIC;
    ma_cyc[k] = 1'b1; ma_stb[k] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      n = 0;
      @(negedge clk);
      while (!(m_ack_o[k] || m_err_o[k]) && n < 100 && !abort) begin
        n++;
        @(negedge clk);
      end
      if (abort) begin
        ma_cyc[k] = 1'b0; ma_stb[k] = 1'b0;
        return;
      end
      if (n >= 100) begin
        chk_cnt++;
        err_cnt++;
        $display("FAIL resp_wait master %0d: got no response expected one within 100 cycles", k);
        ma_cyc[k] = 1'b0; ma_stb[k] = 1'b0;
        return;
      end
      if (b < beats - 1) begin
        @(posedge clk); #1;
        ma_adr[k] = ma_adr[k] + 32'd4;
        if (b + 1 == beats - 1) ma_cti[k] = CTI_EOB;
      end
    end
    @(posedge clk); #1;
    ma_cyc[k] = 1'b0; ma_stb[k] = 1'b0;
  endtask

  task automatic clr_masters();
    for (int k = 0; k < 3; k++) begin
      ma_adr[k] = '0; ma_sel[k] = '0; ma_cti[k] = '0; ma_bte[k] = '0;
      ma_we[k] = 1'b0; ma_cyc[k] = 1'b0; ma_stb[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    abort = 1'b0;
    slv_never = 1'b0;
    clr_masters();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic end_test();
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    clr_masters();
    rst_n = 1'b0;
    // Reset state with a master already requesting
    ma_cyc[0] = 1'b1; ma_stb[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant_o, 2'd3);
    check("rst_scyc", s_cyc_o, 1'b0);
    check("rst_sstb", s_stb_o, 1'b0);
    check("rst_resp", {m_ack_o, m_err_o, m_rty_o}, 9'd0);
    clr_masters();
    @(posedge clk); #1 rst_n = 1'b1;

    // Single read by master 1, slave acks after 2 cycles
    slv_lat = 2;
    push_exp(3'b010, 3'b000, 2'd1, 32'hA5A5_0100, 1'b1, 1'b0);
    fork
      do_access(1, 32'h100, 1, n1);
      begin
        @(posedge clk);
        @(negedge clk);
        check("scyc_lat_c0", s_cyc_o, 1'b0);
        @(negedge clk);
        check("scyc_lat_c1", s_cyc_o, 1'b1);
        check("sadr_mux", s_adr_o, 32'h100);
        check("sdat_mux", s_dat_o, 32'hD1D1_D1D1);
      end
    join
    check("m1_latency", n1, 3);
    end_test();

    // All three request from reset: grants 0,1,2 back to back
    do_reset();
    slv_lat = 1;
    gtrace.delete();
    g_prev = 2'd3;
    tr_en = 1'b1;
    push_exp(3'b001, 3'b000, 2'd0, 32'hA5A5_0400, 1'b1, 1'b0);
    push_exp(3'b010, 3'b000, 2'd1, 32'hA5A5_0500, 1'b1, 1'b0);
    push_exp(3'b100, 3'b000, 2'd2, 32'hA5A5_0600, 1'b1, 1'b0);
    fork
      do_access(0, 32'h400, 1, n0);
      do_access(1, 32'h500, 1, n1);
      do_access(2, 32'h600, 1, n2);
    join
    end_test();
    tr_en = 1'b0;
    gexp[0] = 2'd0; gexp[1] = 2'd1; gexp[2] = 2'd2; gexp[3] = 2'd3;
    check("gtrace_len", gtrace.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < gtrace.size()) check("gtrace", gtrace[i], gexp[i]);

    // 4-beat incrementing burst by master 0 while master 2 waits
    do_reset();
    slv_lat = 1;
    push_exp(3'b001, 3'b000, 2'd0, 32'hA5A5_0200, 1'b1, 1'b0);
    push_exp(3'b001, 3'b000, 2'd0, 32'hA5A5_0204, 1'b1, 1'b0);
    push_exp(3'b001, 3'b000, 2'd0, 32'hA5A5_0208, 1'b1, 1'b0);
    push_exp(3'b001, 3'b000, 2'd0, 32'hA5A5_020C, 1'b1, 1'b0);
    push_exp(3'b100, 3'b000, 2'd2, 32'hA5A5_0700, 1'b1, 1'b0);
    fork
      begin
        do_access(0, 32'h200, 4, n0);
        @(negedge clk);
        check("hold_on_drop", grant_o, 2'd0);
        @(negedge clk);
        check("handover_to_2", grant_o, 2'd2);
      end
      begin
        @(posedge clk);
        do_access(2, 32'h700, 1, n2);
      end
    join
    end_test();

    // Slave never answers: forced error after 8 stalled cycles
    do_reset();
    slv_never = 1'b1;
    push_exp(3'b000, 3'b010, 2'd1, 32'h0, 1'b0, 1'b1);
    do_access(1, 32'h800, 1, n1);
    check("tmo_latency", n1, 9);
    slv_never = 1'b0;
    end_test();

    // Ack lands exactly on the timeout cycle: ack wins, no error
    do_reset();
    slv_lat = 8;
    push_exp(3'b010, 3'b000, 2'd1, 32'hA5A5_0900, 1'b1, 1'b0);
    do_access(1, 32'h900, 1, n1);
    check("coincide_latency", n1, 9);
    end_test();

    // Reset mid-transfer, then master 0 must win over master 2
    do_reset();
    slv_never = 1'b1;
    fork
      do_access(1, 32'hA00, 1, n1);
    join_none
    repeat (4) @(negedge clk);
    check("own_before_rst", grant_o, 2'd1);
    rst_n = 1'b0;
    abort = 1'b1;
    #1;
    check("midrst_grant", grant_o, 2'd3);
    check("midrst_resp", {m_ack_o, m_err_o, m_rty_o}, 9'd0);
    check("midrst_scyc", s_cyc_o, 1'b0);
    check("midrst_sstb", s_stb_o, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    slv_never = 1'b0;
    slv_lat = 1;
    abort = 1'b0;
    rst_n = 1'b1;
    push_exp(3'b001, 3'b000, 2'd0, 32'hA5A5_0B00, 1'b1, 1'b0);
    push_exp(3'b100, 3'b000, 2'd2, 32'hA5A5_0C00, 1'b1, 1'b0);
    fork
      do_access(0, 32'hB00, 1, n0);
      do_access(2, 32'hC00, 1, n2);
    join
    end_test();

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire

// File: doc/mpsoc_wb_arb3.md
MPSOC_WB_ARB3 -- requirements
Module: mpsoc_wb_arb3

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning Wishbone address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning Wishbone data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning stalled-access cycles before a forced error (range 1..1023).
REQ-004 The block SHALL have port wb_clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port wb_rst_ni, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have ports m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i and m_bte_i, all inputs, sized 3*AW, 3*DW, 3*DW/8, 3, 3, 3, 3*3 and 3*2 bits, carrying the master requests; slice k is master k (0=or1k_i, 1=or1k_d, 2=dbg).
REQ-007 The block SHALL have ports m_dat_o, m_ack_o, m_err_o and m_rty_o, all outputs, sized 3*DW, 3, 3 and 3 bits, carrying the per-master responses.
REQ-008 The block SHALL have ports s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o and s_bte_o, all outputs, forming the single slave request port.
REQ-009 The block SHALL have ports s_dat_i, s_ack_i, s_err_i and s_rty_i, all inputs, forming the slave response.
REQ-010 The block SHALL have port grant_o, output, 2 bits, giving the current owner (0..2), or 3 when there is no owner.

Function
REQ-011 The arbiter SHALL be a two-state FSM: IDLE (no owner) and OWN (grant register holds owner k).
REQ-012 In IDLE with any m_cyc_i high, the FSM SHALL register the winner and enter OWN at the next edge; the slave sees the request one cycle after the master raises cyc.
REQ-013 The winner SHALL be chosen round-robin: search starts at last_owner+1 mod 3 and takes the first master with cyc high.
REQ-014 In OWN, the grant SHALL be held while the owner's m_cyc_i is high, which keeps CTI 3'b010 bursts and BTE wrap bursts atomic.
REQ-015 When the owner drops cyc, the FSM SHALL at the next edge grant the next round-robin requester directly (no idle cycle), or return to IDLE if none is requesting.
REQ-016 The slave request outputs SHALL be a combinational mux of the owner's signals; with no owner, s_cyc_o and s_stb_o SHALL be 0.
REQ-017 m_dat_o SHALL broadcast s_dat_i to all slices, and ack, err and rty SHALL be routed only to the owner; non-owners see 0.
REQ-018 A watchdog counter SHALL increment each cycle that s_cyc_o&s_stb_o is high and s_ack_i|s_err_i|s_rty_i is low, and SHALL clear on any response, on loss of stb, or on a grant change.
REQ-019 When the counter equals TIMEOUT, the owner SHALL receive m_err_o for exactly one cycle, s_stb_o SHALL be forced 0 in that cycle, and the counter SHALL clear.
REQ-020 If a slave response arrives in the same cycle as the timeout, the slave response SHALL win and no error is injected.
REQ-021 A requester that drops cyc before it is granted SHALL be skipped without penalty.

Reset
REQ-022 Asserting wb_rst_ni low SHALL immediately force: FSM=IDLE, grant_o=3, last_owner=2 (so master 0 has first priority), watchdog counter=0, all s_* strobes 0, and all m_ack_o, m_err_o and m_rty_o 0.
REQ-023 Reset asserted mid-burst SHALL abandon the transfer with no response generated, and arbitration SHALL resume from the reset state on deassertion.

Structure
REQ-024 Package mpsoc_wb_arb_pkg SHALL hold the state enum (IDLE, OWN), the CTI and BTE constants, the NO_OWNER=2'd3 constant, and the master index constants.
REQ-025 The round-robin picker SHALL be a sub-module mpsoc_wb_arb_rr: a 3-bit request plus last_owner in, a 2-bit winner and a valid flag out.
REQ-026 The watchdog counter width SHALL be $clog2(TIMEOUT+1).

Verification
REQ-027 With only master 1 single read at 0x100 and the slave acking after 2 cycles, s_cyc_o SHALL rise 1 cycle after m_cyc_i[1], and m_ack_o[1] SHALL equal s_ack_i with m_ack_o[0] and m_ack_o[2] both 0.
REQ-028 With all three masters requesting from reset, each doing a single access, grants SHALL be 0,1,2 in order with no idle cycle between handovers.
REQ-029 With master 0 performing a 4-beat CTI=010 incrementing burst while master 2 requests, grant SHALL stay 0 for all 4 acks and switch to 2 on the cycle after master 0 drops cyc.
REQ-030 With TIMEOUT=8 and a slave that never responds, m_err_o[owner] SHALL pulse once after 8 stalled cycles with s_stb_o 0 in that cycle.
REQ-031 When s_ack_i coincides with the timeout cycle, ack SHALL be delivered and no error pulse SHALL occur.
REQ-032 With wb_rst_ni pulsed low mid-burst, grant_o SHALL be 3 immediately, all responses SHALL be 0, and master 0 SHALL be granted first after release.
